phyreg_freelist: RTL and testbench
==================================

PHYREG_FREELIST -- requirements
Module: phyreg_freelist

Interface
REQ-001 SHALL have parameter NUM_OF_PHYREGS, default 96, total physical registers.
REQ-002 SHALL have parameter NUM_OF_LOGREGS, default 32, logical registers; physical indices 0..NUM_OF_LOGREGS-1 are the initial architectural mapping and never start in the list.
REQ-003 SHALL have parameter NUM_OF_FETCH, default 4, maximum allocations per cycle.
REQ-004 SHALL have parameter NUM_OF_GRADUATE, default 4, maximum frees per cycle.
REQ-005 SHALL define D = NUM_OF_PHYREGS-NUM_OF_LOGREGS (64), IW = $clog2(NUM_OF_PHYREGS) (7), PW = $clog2(D) (6), CW = $clog2(D+1) (7).
REQ-006 clk  input  1  single clock; all state updates on rising edge.
REQ-007 rst_n  input  1  asynchronous, active-low reset.
REQ-008 alloc_num  input  $clog2(NUM_OF_FETCH+1)  number of registers rename requests this cycle (0..NUM_OF_FETCH).
REQ-009 alloc_ready  output  1  list can satisfy NUM_OF_FETCH allocations this cycle.
REQ-010 alloc_idx  output  NUM_OF_FETCH x IW  next free indices, slot k = entry head+k.
REQ-011 free_valid  input  NUM_OF_GRADUATE  per-graduation-slot release strobe.
REQ-012 free_idx  input  NUM_OF_GRADUATE x IW  physical index released per slot.
REQ-013 free_count  output  CW  current number of entries in the list (registered).

Function
REQ-014 SHALL store free indices in a circular buffer of D entries with registered head, tail (PW bits, wrap mod D) and count (CW bits).
REQ-015 alloc_ready SHALL be combinational from registered count: 1 iff count >= NUM_OF_FETCH.
REQ-016 alloc_idx[k] SHALL equal buffer[(head+k) mod D], driven every cycle regardless of alloc_num.
REQ-017 Allocation SHALL fire iff alloc_num != 0 and alloc_ready; then head <= (head+alloc_num) mod D.
REQ-018 alloc_num != 0 while alloc_ready = 0 SHALL leave head unchanged; requester must stall.
REQ-019 Frees SHALL be compacted in ascending slot order: the j-th set bit of free_valid writes buffer[(tail+j) mod D]; tail <= (tail+popcount(free_valid)) mod D.
REQ-020 Non-contiguous free_valid (e.g. 4'b1010) SHALL be legal and produce contiguous writes.
REQ-021 count SHALL update as count - (fired ? alloc_num : 0) + popcount(free_valid), same cycle for simultaneous alloc and free.
REQ-022 Indices written by a free SHALL become visible on alloc_idx no earlier than the next cycle; no bypass.
REQ-023 Full (count = D) with head = tail and empty (count = 0) with head = tail SHALL be distinguished by count only.
REQ-024 Frees making count exceed D, or alloc_num > NUM_OF_FETCH, are illegal; simulation assertions SHALL flag them; RTL behaviour then undefined.
REQ-025 Latency: allocation result consumed in the request cycle (combinational alloc_idx); state update 1 cycle.

Reset
REQ-026 On rst_n low, asynchronously: buffer[i] = NUM_OF_LOGREGS+i for i in 0..D-1, head = 0, tail = 0, count = D.
REQ-027 Outputs during/after reset: free_count = 64, alloc_ready = 1, alloc_idx = {32,33,34,35} (slot 0 first).
REQ-028 Reset asserted mid-operation SHALL discard all pending allocs/frees in that cycle and restore REQ-026 state.

Verification
REQ-029 Reset, alloc_num=4 for 1 cycle -> alloc_idx {32,33,34,35}; next cycle alloc_idx {36,37,38,39}, free_count 60.
REQ-030 Allocate 4/cycle for 15 cycles (count 4), then alloc_num=4 -> fires, count 0, alloc_ready 0; further alloc_num=4 -> head/count unchanged.
REQ-031 From count 0, free_valid=4'b1010, free_idx slot1=40, slot3=45 -> next cycle count 2, buffer[tail],buffer[tail+1] = 40,45; alloc_ready stays 0.
REQ-032 count 10, same cycle alloc_num=3 and free_valid=4'b1111 -> count 11; freed indices appear only after 7 more allocations.
REQ-033 Run head and tail across the 63->0 wrap with mixed 1..4 allocs/frees for 1000 random cycles -> scoreboard: every allocated index unique among in-flight, free_count matches model.
REQ-034 Assert rst_n mid-burst (alloc_num=4, free_valid=4'b1111) -> immediately count 64, alloc_idx {32,33,34,35}, no buffer writes retained.

Source files
------------

// File: rtl/phyreg_freelist_if.sv
// Interface between the physical register free list and its users.
// The rename stage reads allocation indices and requests a count, and the
// graduation stage hands back physical registers for reuse.
interface phyreg_freelist_if #(
    parameter int NUM_OF_PHYREGS  = 96,
    parameter int NUM_OF_LOGREGS  = 32,
    parameter int NUM_OF_FETCH    = 4,
    parameter int NUM_OF_GRADUATE = 4
);
    localparam int D  = NUM_OF_PHYREGS - NUM_OF_LOGREGS;
    localparam int IW = $clog2(NUM_OF_PHYREGS);
    localparam int CW = $clog2(D + 1);
    localparam int AW = $clog2(NUM_OF_FETCH + 1);

    logic [AW-1:0]                      alloc_num;
    logic                               alloc_ready;
    logic [NUM_OF_FETCH-1:0][IW-1:0]    alloc_idx;
    logic [NUM_OF_GRADUATE-1:0]         free_valid;
    logic [NUM_OF_GRADUATE-1:0][IW-1:0] free_idx;
    logic [CW-1:0]                      free_count;

    modport master (
        output alloc_num,
        output free_valid,
        output free_idx,
        input  alloc_ready,
        input  alloc_idx,
        input  free_count
    );

    modport slave (
        input  alloc_num,
        input  free_valid,
        input  free_idx,
        output alloc_ready,
        output alloc_idx,
        output free_count
    );
endinterface

// File: rtl/phyreg_freelist.sv
// Physical register free list: a circular buffer of free physical indices.
// Rename takes indices from the head (up to NUM_OF_FETCH per cycle), and
// graduation returns indices at the tail (up to NUM_OF_GRADUATE per cycle,
// compacted so a sparse strobe still fills consecutive entries).
// Full and empty both have head == tail; only the count tells them apart.
module phyreg_freelist #(
    parameter int NUM_OF_PHYREGS  = 96,
    parameter int NUM_OF_LOGREGS  = 32,
    parameter int NUM_OF_FETCH    = 4,
    parameter int NUM_OF_GRADUATE = 4
) (
    input logic             clk,
    input logic             rst_n,
    phyreg_freelist_if.slave bus
);
    localparam int D  = NUM_OF_PHYREGS - NUM_OF_LOGREGS;
    localparam int IW = $clog2(NUM_OF_PHYREGS);
    localparam int PW = $clog2(D);
    localparam int CW = $clog2(D + 1);
    localparam int AW = $clog2(NUM_OF_FETCH + 1);
    localparam int GW = $clog2(NUM_OF_GRADUATE + 1);

    localparam logic [PW:0]   D_PTR     = (PW + 1)'(D);
    localparam logic [CW:0]   D_CNT     = (CW + 1)'(D);
    localparam logic [CW-1:0] FETCH_CNT = CW'(NUM_OF_FETCH);
    localparam logic [AW-1:0] FETCH_NUM = AW'(NUM_OF_FETCH);

    logic [IW-1:0] buffer [D];
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [CW-1:0] count;

    logic          alloc_ready;
    logic          fire;
    logic [AW-1:0] alloc_amt;
    logic [GW-1:0] free_pop;
    logic [PW-1:0] wr_addr [NUM_OF_GRADUATE];
    logic [PW-1:0] head_next;
    logic [PW-1:0] tail_next;
    logic [CW:0]   count_sum;

    // Pointer advance modulo D; offset is always smaller than D.
    function automatic logic [PW-1:0] wrap_add(input logic [PW-1:0] base,
                                               input logic [PW:0]   offset);
        logic [PW:0] sum;
        sum = {1'b0, base} + offset;
        if (sum >= D_PTR) begin
            sum = sum - D_PTR;
        end
        return sum[PW-1:0];
    endfunction

    assign alloc_ready     = (count >= FETCH_CNT);
    assign bus.alloc_ready = alloc_ready;
    assign bus.free_count  = count;

    // Present the next NUM_OF_FETCH free entries straight from the buffer.
    always_comb begin
        bus.alloc_idx = '0;
        for (int k = 0; k < NUM_OF_FETCH; k++) begin
            bus.alloc_idx[k] = buffer[wrap_add(head, (PW + 1)'(k))];
        end
    end

    // Work out the allocation, compacted free addresses and next pointers/count.
    always_comb begin
        fire      = (bus.alloc_num != '0) && alloc_ready;
        alloc_amt = fire ? bus.alloc_num : '0;
        free_pop  = '0;
        for (int g = 0; g < NUM_OF_GRADUATE; g++) begin
            wr_addr[g] = wrap_add(tail, (PW + 1)'(free_pop));
            if (bus.free_valid[g]) begin
                free_pop = free_pop + GW'(1);
            end
        end
        head_next = wrap_add(head, (PW + 1)'(alloc_amt));
        tail_next = wrap_add(tail, (PW + 1)'(free_pop));
        count_sum = (CW + 1)'(count) - (CW + 1)'(alloc_amt) + (CW + 1)'(free_pop);
    end

    // Head, tail and occupancy registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head  <= '0;
            tail  <= '0;
            count <= CW'(D);
        end else begin
            head  <= head_next;
            tail  <= tail_next;
            count <= count_sum[CW-1:0];
        end
    end

    // Buffer storage: reset to the non-architectural indices, then write frees.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < D; i++) begin
                buffer[i] <= IW'(NUM_OF_LOGREGS + i);
            end
        end else begin
            for (int g = 0; g < NUM_OF_GRADUATE; g++) begin
                if (bus.free_valid[g]) begin
                    buffer[wr_addr[g]] <= bus.free_idx[g];
                end
            end
        end
    end

    // Catch illegal use: oversized requests and frees that overflow the list.
    a_alloc_num_legal: assert property (@(posedge clk) disable iff (!rst_n)
        bus.alloc_num <= FETCH_NUM);
    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        count_sum <= D_CNT);
endmodule

// File: tb/tb_phyreg_freelist.sv
// Testbench for phyreg_freelist: directed scenarios with literal expectations
// plus a queue-based reference model checked every cycle.
module tb_phyreg_freelist;
    localparam int NUM_OF_PHYREGS  = 96;
    localparam int NUM_OF_LOGREGS  = 32;
    localparam int NUM_OF_FETCH    = 4;
    localparam int NUM_OF_GRADUATE = 4;
    localparam int D  = NUM_OF_PHYREGS - NUM_OF_LOGREGS;
    localparam int IW = $clog2(NUM_OF_PHYREGS);
    localparam int AW = $clog2(NUM_OF_FETCH + 1);

    typedef logic [NUM_OF_GRADUATE-1:0][IW-1:0] free_vec_t;

    logic clk;
    logic rst_n;

    int total;
    int bad;
    bit compare_en;

    int model_q[$];
    int inflight[$];

    phyreg_freelist_if #(
        .NUM_OF_PHYREGS (NUM_OF_PHYREGS),
        .NUM_OF_LOGREGS (NUM_OF_LOGREGS),
        .NUM_OF_FETCH   (NUM_OF_FETCH),
        .NUM_OF_GRADUATE(NUM_OF_GRADUATE)
    ) bus ();

    phyreg_freelist #(
        .NUM_OF_PHYREGS (NUM_OF_PHYREGS),
        .NUM_OF_LOGREGS (NUM_OF_LOGREGS),
        .NUM_OF_FETCH   (NUM_OF_FETCH),
        .NUM_OF_GRADUATE(NUM_OF_GRADUATE)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        total++;
        if (actual != expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    // Free list after reset: all non-architectural indices in order.
    task automatic modelReset();
        model_q.delete();
        inflight.delete();
        for (int i = 0; i < D; i++) begin
            model_q.push_back(NUM_OF_LOGREGS + i);
        end
    endtask

    function automatic int inInflight(input int v);
        foreach (inflight[i]) begin
            if (inflight[i] == v) return 1;
        end
        return 0;
    endfunction

    task automatic idleInputs();
        bus.alloc_num  = '0;
        bus.free_valid = '0;
        bus.free_idx   = '0;
    endtask

    // Drive one cycle of requests, then advance the model the same way the list must.
    task automatic applyStimulus(input int num, input logic [NUM_OF_GRADUATE-1:0] mask,
                                 input free_vec_t fidx);
        bit fired;
        bus.alloc_num  = AW'(num);
        bus.free_valid = mask;
        bus.free_idx   = fidx;
        @(posedge clk);
        fired = (num != 0) && (model_q.size() >= NUM_OF_FETCH);
        if (fired) begin
            for (int k = 0; k < num; k++) begin
                inflight.push_back(model_q.pop_front());
            end
        end
        for (int g = 0; g < NUM_OF_GRADUATE; g++) begin
            if (mask[g]) model_q.push_back(int'(fidx[g]));
        end
        #1;
        idleInputs();
    endtask

    task automatic doReset();
        rst_n = 1'b0;
        modelReset();
        idleInputs();
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic checkIdx(input string tag, input int a0, input int a1, input int a2, input int a3);
        checkOutput({tag, "_idx0"}, int'(bus.alloc_idx[0]), a0);
        checkOutput({tag, "_idx1"}, int'(bus.alloc_idx[1]), a1);
        checkOutput({tag, "_idx2"}, int'(bus.alloc_idx[2]), a2);
        checkOutput({tag, "_idx3"}, int'(bus.alloc_idx[3]), a3);
    endtask

    // Every cycle: outputs must match the queue model (only valid slots for alloc_idx).
    always @(negedge clk) begin
        if (compare_en) begin
            checkOutput("m_free_count", int'(bus.free_count), model_q.size());
            checkOutput("m_alloc_ready", int'(bus.alloc_ready),
                        (model_q.size() >= NUM_OF_FETCH) ? 1 : 0);
            for (int k = 0; k < NUM_OF_FETCH; k++) begin
                if (k < model_q.size()) begin
                    checkOutput($sformatf("m_alloc_idx%0d", k), int'(bus.alloc_idx[k]), model_q[k]);
                end
            end
        end
    end

    initial begin
        int num;
        logic [NUM_OF_GRADUATE-1:0] mask;
        free_vec_t fidx;

        total = 0;
        bad = 0;
        compare_en = 1'b0;
        rst_n = 1'b0;
        modelReset();
        idleInputs();
        #1;
        compare_en = 1'b1;
        doReset();

        // Reset state
        checkOutput("rst_count", int'(bus.free_count), 64);
        checkOutput("rst_ready", int'(bus.alloc_ready), 1);
        checkIdx("rst", 32, 33, 34, 35);

        // First allocation and the next window
        applyStimulus(4, 4'b0000, '0);
        checkIdx("a1", 36, 37, 38, 39);
        checkOutput("a1_count", int'(bus.free_count), 60);

        // Drain to four, then to empty, then a stalled request
        repeat (14) applyStimulus(4, 4'b0000, '0);
        checkOutput("a15_count", int'(bus.free_count), 4);
        checkOutput("a15_ready", int'(bus.alloc_ready), 1);
        checkIdx("a15", 92, 93, 94, 95);
        applyStimulus(4, 4'b0000, '0);
        checkOutput("empty_count", int'(bus.free_count), 0);
        checkOutput("empty_ready", int'(bus.alloc_ready), 0);
        applyStimulus(4, 4'b0000, '0);
        checkOutput("stall_count", int'(bus.free_count), 0);
        checkOutput("stall_ready", int'(bus.alloc_ready), 0);

        // Sparse free strobe is compacted; head stayed put during the stall
        fidx = '0;
        fidx[1] = 7'd40;
        fidx[3] = 7'd45;
        applyStimulus(0, 4'b1010, fidx);
        checkOutput("sparse_count", int'(bus.free_count), 2);
        checkOutput("sparse_ready", int'(bus.alloc_ready), 0);
        checkOutput("sparse_idx0", int'(bus.alloc_idx[0]), 40);
        checkOutput("sparse_idx1", int'(bus.alloc_idx[1]), 45);

        // Simultaneous allocate and free, freed entries appear behind the older ones
        doReset();
        repeat (13) applyStimulus(4, 4'b0000, '0);
        applyStimulus(2, 4'b0000, '0);
        checkOutput("c10_count", int'(bus.free_count), 10);
        checkIdx("c10", 86, 87, 88, 89);
        applyStimulus(3, 4'b1111, {7'd35, 7'd34, 7'd33, 7'd32});
        checkOutput("mix_count", int'(bus.free_count), 11);
        checkIdx("mix", 89, 90, 91, 92);
        applyStimulus(4, 4'b0000, '0);
        checkOutput("mix4_count", int'(bus.free_count), 7);
        checkIdx("mix4", 93, 94, 95, 32);
        applyStimulus(3, 4'b0000, '0);
        checkOutput("mix7_count", int'(bus.free_count), 4);
        checkIdx("mix7", 32, 33, 34, 35);

        // Reset asserted in the middle of a burst
        bus.alloc_num  = AW'(4);
        bus.free_valid = 4'b1111;
        bus.free_idx   = {7'd4, 7'd3, 7'd2, 7'd1};
        #3;
        rst_n = 1'b0;
        modelReset();
        #1;
        checkOutput("midrst_count", int'(bus.free_count), 64);
        checkOutput("midrst_ready", int'(bus.alloc_ready), 1);
        checkIdx("midrst", 32, 33, 34, 35);
        @(posedge clk);
        #1;
        checkOutput("midrst_hold_count", int'(bus.free_count), 64);
        checkIdx("midrst_hold", 32, 33, 34, 35);
        idleInputs();
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        applyStimulus(4, 4'b0000, '0);
        checkIdx("post_rst", 36, 37, 38, 39);
        repeat (15) applyStimulus(4, 4'b0000, '0);
        checkOutput("post_rst_drained", int'(bus.free_count), 0);

        // Random mixed traffic across the pointer wrap
        doReset();
        for (int c = 0; c < 1000; c++) begin
            num  = $urandom_range(0, NUM_OF_FETCH);
            mask = NUM_OF_GRADUATE'($urandom_range(0, (1 << NUM_OF_GRADUATE) - 1));
            fidx = '0;
            for (int g = 0; g < NUM_OF_GRADUATE; g++) begin
                if (mask[g] && inflight.size() > 0) begin
                    int p;
                    p = $urandom_range(0, inflight.size() - 1);
                    fidx[g] = IW'(inflight[p]);
                    inflight.delete(p);
                end else begin
                    mask[g] = 1'b0;
                end
            end
            if (num != 0 && model_q.size() >= NUM_OF_FETCH) begin
                for (int k = 0; k < num; k++) begin
                    checkOutput("uniq", inInflight(int'(bus.alloc_idx[k])), 0);
                end
            end
            applyStimulus(num, mask, fidx);
        end

        @(posedge clk);
        #1;
        compare_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
